// File: rtl/key_debounce_array_if.sv
// Key debouncer bus: raw key pins and repeat enables in, debounced level and
// one-cycle event pulses out. The master drives the keys; the slave is the debouncer.
interface key_debounce_array_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_raw, repeat_en,
    input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  key_raw, repeat_en,
    output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer with press/release/long-press/auto-repeat events.
// Each channel: 2-flop synchronizer, debounce counter, and an IDLE/PRESSED/HELD/REPEAT
// machine driven by a hold counter. All outputs come straight from flops.
module key_debounce_array #(
  parameter int N_KEYS        = 3,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 nreset,
  key_debounce_array_if.slave  kbus
);

  localparam int DW       = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [N_KEYS-1:0] RAW_IDLE  = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
  localparam logic [DW-1:0]     DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]     LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]     REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_SAT  = {HW{1'b1}};

  typedef enum logic [1:0] {IDLE, PRESSED, HELD, REPEAT} state_e;

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n_i;
  logic [N_KEYS-1:0] meta_q, meta_d, sync_q, sync_d;
  logic [N_KEYS-1:0] pressed_s;

  logic [DW-1:0]     deb_cnt_q  [N_KEYS];
  logic [DW-1:0]     deb_cnt_d  [N_KEYS];
  logic [HW-1:0]     hold_cnt_q [N_KEYS];
  logic [HW-1:0]     hold_cnt_d [N_KEYS];
  state_e            state_q    [N_KEYS];
  state_e            state_d    [N_KEYS];

  logic [N_KEYS-1:0] key_level_q, key_level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;

  // Next value of the reset and key synchronizer chains
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    meta_d     = kbus.key_raw;
    sync_d     = meta_q;
  end

  // Reset synchronizer: asserts with nreset, releases two edges later
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rst_sync_q <= 2'b00;
    else         rst_sync_q <= rst_sync_d;
  end

  assign rst_n_i = rst_sync_q[1];

  // Key synchronizers sit on the raw reset so they refill while the counters
  // are still held by the synchronized reset; this keeps post-reset latency at 2+DEB_CYCLES.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= RAW_IDLE;
      sync_q <= RAW_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign pressed_s = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;

  // Per-channel debounce, event machine and pulse generation
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    state_d     = state_q;
    key_level_d = key_level_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    repeat_d    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (pressed_s[i] == key_level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i]   = '0;
        key_level_d[i] = ~key_level_q[i];
        press_d[i]     = ~key_level_q[i];
        release_d[i]   = key_level_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end

      case (state_q[i])
        IDLE: begin
          hold_cnt_d[i] = '0;
          if (press_d[i]) state_d[i] = PRESSED;
        end
        PRESSED: begin
          if (hold_cnt_q[i] == LONG_LAST) begin
            long_d[i]     = 1'b1;
            hold_cnt_d[i] = '0;
            state_d[i]    = kbus.repeat_en[i] ? REPEAT : HELD;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
          end
        end
        HELD: begin
          if (kbus.repeat_en[i]) begin
            state_d[i]    = REPEAT;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] != HOLD_SAT) begin
            hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
          end
        end
        REPEAT: begin
          if (!kbus.repeat_en[i]) begin
            state_d[i]    = HELD;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == REP_LAST) begin
            repeat_d[i]   = 1'b1;
            hold_cnt_d[i] = '0;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
          end
        end
        default: begin
          state_d[i]    = IDLE;
          hold_cnt_d[i] = '0;
        end
      endcase

      // An accepted release overrides any long/repeat event in the same cycle
      if (release_d[i]) begin
        state_d[i]    = IDLE;
        hold_cnt_d[i] = '0;
        long_d[i]     = 1'b0;
        repeat_d[i]   = 1'b0;
      end
    end
  end

  // Channel state and output registers
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= IDLE;
      end
      key_level_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign kbus.key_level     = key_level_q;
  assign kbus.press_pulse   = press_q;
  assign kbus.release_pulse = release_q;
  assign kbus.long_pulse    = long_q;
  assign kbus.repeat_pulse  = repeat_q;

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- N_KEYS, 3, number of independent key channels (1..16).
- ACTIVE_LOW, 1, 1 means raw key reads 0 when pressed; 0 means raw key reads 1 when pressed.
- DEB_CYCLES, 1_000_000, stable-sample count needed to accept a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50_000_000, pressed duration before the long-press event (1 s); must exceed DEB_CYCLES.
- REPEAT_CYCLES, 10_000_000, auto-repeat period after the long-press event (200 ms); minimum 2.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, input, 1, single system clock.
- nreset, input, 1, reset; asynchronous assert, active-low.
- key_raw, input, N_KEYS, asynchronous raw key pins.
- repeat_en, input, N_KEYS, per-channel auto-repeat enable, sampled every cycle.
- key_level, output, N_KEYS, debounced level; 1 means pressed.
- press_pulse, output, N_KEYS, one-cycle pulse on an accepted press.
- release_pulse, output, N_KEYS, one-cycle pulse on an accepted release.
- long_pulse, output, N_KEYS, one-cycle pulse at the long-press threshold.
- repeat_pulse, output, N_KEYS, one-cycle auto-repeat pulses.
REQ-003 All outputs SHALL be driven from registers; none is combinational from key_raw.

Function
REQ-004 Each channel SHALL pass key_raw through a 2-flop synchronizer, then normalise polarity per ACTIVE_LOW, giving sync (1 means pressed).
REQ-005 Each channel SHALL keep a debounce counter of width $clog2(DEB_CYCLES+1):
- cleared in any cycle where sync == key_level;
- incremented in any cycle where sync != key_level;
- on reaching DEB_CYCLES-1 with sync still != key_level, key_level toggles at the next edge and the counter clears.
REQ-006 Any glitch shorter than DEB_CYCLES consecutive differing samples SHALL leave key_level unchanged and produce no pulse.
REQ-007 Latency SHALL be: from a clean key_raw edge to the key_level change = 2 (sync) + DEB_CYCLES cycles.
REQ-008 press_pulse SHALL be high for exactly the one cycle in which key_level first reads 1; release_pulse likewise in the cycle key_level first reads 0.
REQ-009 Per channel, a state machine SHALL have states IDLE, PRESSED, HELD and REPEAT:
- IDLE to PRESSED on an accepted press.
- PRESSED to HELD when the hold counter reaches LONG_CYCLES after the press.
- HELD to REPEAT immediately if repeat_en=1.
- Any state to IDLE on an accepted release.
REQ-010 The hold counter SHALL be of width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1), clear in IDLE, and saturate, never wrap, in HELD while repeat_en=0.
REQ-011 long_pulse SHALL fire once per press, in the cycle of the PRESSED to HELD transition; it SHALL NOT fire if release is accepted before the threshold.
REQ-012 In REPEAT, repeat_pulse SHALL fire every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES after long_pulse; the counter reloads on each pulse.
REQ-013 repeat_en falling in REPEAT SHALL move the channel to HELD with no further pulse. repeat_en rising in HELD SHALL enter REPEAT with the counter cleared, first pulse REPEAT_CYCLES later.
REQ-014 If the release is accepted in the same cycle a long or repeat pulse would fire, the release SHALL win: release_pulse fires and the long or repeat pulse is suppressed.
REQ-015 Channels SHALL be fully independent; simultaneous events on several channels SHALL all produce their pulses in the same cycle.

Reset
REQ-016 While nreset=0, all outputs SHALL be 0, all state machines SHALL be IDLE, all counters 0, and synchronizer flops set to the released level.
REQ-017 Reset asserted mid-press SHALL discard the press. After deassertion, a key still held SHALL be re-accepted as a new press after 2+DEB_CYCLES cycles, with press_pulse.
REQ-018 Deassertion SHALL be synchronised to clk inside the block.

Verification
Use N_KEYS=3, ACTIVE_LOW=1, DEB_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=8 for all scenarios.
REQ-019 Clean press: key_raw[0] 1 to 0, held 20 cycles, then 1 -> press_pulse[0] exactly 10 cycles after the edge, release_pulse[0] 10 cycles after the rise, no long_pulse.
REQ-020 Bounce: key_raw[1] toggling every 3 cycles for 30 cycles, then stable 0 -> no pulse during the bounce; a single press_pulse[1] 10 cycles after the last edge.
REQ-021 Long press with repeat: repeat_en[2]=1, hold key 60 cycles -> long_pulse[2] 32 cycles after press_pulse; repeat_pulse[2] at +8, +16 and so on until release.
REQ-022 Release collision: release timed so key_level falls exactly at the long threshold -> release_pulse only, long_pulse=0.
REQ-023 Reset mid-hold: nreset low for 3 cycles while key 0 is held -> all outputs 0; press_pulse[0] 10 cycles after deassertion.
REQ-024 Simultaneous press: all three keys pressed on the same edge -> press_pulse=3'b111 in a single cycle.
